// File: rtl/shared_add_sched.sv
// Round-robin scheduler sharing one 4-bit adder among four requesters.
// One addition in flight at a time; result tagged with owner index.
module shared_add_sched #(
    parameter int ADD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic [3:0]  gnt,
    output logic        busy,
    output logic [4:0]  sum_out,
    output logic        sum_valid,
    output logic [1:0]  sum_id
);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    localparam logic [3:0] LAST = 4'(ADD_LAT - 1);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic [1:0]  ptr;
    logic [1:0]  ptr_nx;
    logic [3:0]  opa;
    logic [3:0]  opa_nx;
    logic [3:0]  opb;
    logic [3:0]  opb_nx;
    logic [1:0]  idx;
    logic [1:0]  idx_nx;
    logic [3:0]  gnt_nx;
    logic [4:0]  sum_nx;
    logic        sv_nx;
    logic [1:0]  sid_nx;
    logic [4:0]  add_res;
    logic        found;
    logic [1:0]  win;
    logic [1:0]  cand;

    assign busy    = (state == CALC);
    assign add_res = {1'b0, opa} + {1'b0, opb};

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        cand  = ptr;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        opa_nx   = opa;
        opb_nx   = opb;
        idx_nx   = idx;
        gnt_nx   = 4'b0000;
        sv_nx    = 1'b0;
        sum_nx   = sum_out;
        sid_nx   = sum_id;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nx = CALC;
                    gnt_nx   = 4'b0001 << win;
                    ptr_nx   = win;
                    idx_nx   = win;
                    opa_nx   = a_in[{win, 2'b00} +: 4];
                    opb_nx   = b_in[{win, 2'b00} +: 4];
                    cnt_nx   = 4'd0;
                end
            end
            CALC: begin
                cnt_nx = cnt + 4'd1;
                if (cnt == LAST) begin
                    state_nx = IDLE;
                    sum_nx   = add_res;
                    sid_nx   = idx;
                    sv_nx    = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            ptr       <= 2'd3;
            opa       <= 4'd0;
            opb       <= 4'd0;
            idx       <= 2'd0;
            gnt       <= 4'b0000;
            sum_out   <= 5'd0;
            sum_valid <= 1'b0;
            sum_id    <= 2'd0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ptr       <= ptr_nx;
            opa       <= opa_nx;
            opb       <= opb_nx;
            idx       <= idx_nx;
            gnt       <= gnt_nx;
            sum_out   <= sum_nx;
            sum_valid <= sv_nx;
            sum_id    <= sid_nx;
        end
    end

endmodule

// File: tb/tb_shared_add_sched.sv
// Scoreboard bench for shared_add_sched, instance 0 at ADD_LAT=2
// and instance 1 at ADD_LAT=1.
module tb_shared_add_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req [2];
    logic [15:0] a [2];
    logic [15:0] b [2];
    logic [3:0]  gnt [2];
    logic        busy [2];
    logic [4:0]  sum_out [2];
    logic        sum_valid [2];
    logic [1:0]  sum_id [2];

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int gcyc [2];
    int gq [$];
    int sq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    shared_add_sched #(.ADD_LAT(2)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req[0]),
        .a_in(a[0]), .b_in(b[0]), .gnt(gnt[0]),
        .busy(busy[0]), .sum_out(sum_out[0]),
        .sum_valid(sum_valid[0]), .sum_id(sum_id[0])
    );

    shared_add_sched #(.ADD_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req[1]),
        .a_in(a[1]), .b_in(b[1]), .gnt(gnt[1]),
        .busy(busy[1]), .sum_out(sum_out[1]),
        .sum_valid(sum_valid[1]), .sum_id(sum_id[1])
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: grants and sums are popped from the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                int e;
                if (gnt[d] != 4'b0000) begin
                    if (gq.size() == 0) begin
                        chk("unexpected_gnt", 32'(gnt[d]), 0);
                    end else begin
                        e = gq.pop_front();
                        chk("gnt", d * 256 + int'(gnt[d]), e);
                    end
                    gcyc[d] = cyc;
                end
                if (sum_valid[d]) begin
                    if (sq.size() == 0) begin
                        chk("unexpected_sum", 1, 0);
                    end else begin
                        e = sq.pop_front();
                        chk("sum", d * 256 + int'(sum_id[d]) * 32
                            + int'(sum_out[d]), e);
                    end
                    chk("latency", cyc - gcyc[d], (d == 0) ? 2 : 1);
                end
            end
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(int d);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            if (gnt[d] != 4'b0000) ok = 1'b1;
        end
        if (!ok) chk("gnt_timeout", 1, 0);
    endtask

    // exp < 0 means the result is never expected (abandoned by reset).
    task automatic one(int d, int i, logic [3:0] av, logic [3:0] bv,
                       int exp);
        a[d][4*i +: 4] = av;
        b[d][4*i +: 4] = bv;
        gq.push_back(d * 256 + (1 << i));
        if (exp >= 0) sq.push_back(d * 256 + i * 32 + exp);
        req[d] = 4'b0001 << i;
        wait_gnt(d);
        req[d] = 4'b0000;
    endtask

    task automatic chk_zero(string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_gnt"}, 32'(gnt[d]), 0);
            chk({tag, "_busy"}, 32'(busy[d]), 0);
            chk({tag, "_sum"}, 32'(sum_out[d]), 0);
            chk({tag, "_sv"}, 32'(sum_valid[d]), 0);
            chk({tag, "_id"}, 32'(sum_id[d]), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 4'b0000;
            a[d]   = 16'h0000;
            b[d]   = 16'h0000;
            gcyc[d] = 0;
        end
        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Fairness: all four held, order 0,1,2,3,0, three cycles apart.
        a[0] = 16'h8421;
        b[0] = 16'h9753;
        gq.push_back(1);  sq.push_back(0 * 32 + 5'h04);
        gq.push_back(2);  sq.push_back(1 * 32 + 5'h07);
        gq.push_back(4);  sq.push_back(2 * 32 + 5'h0B);
        gq.push_back(8);  sq.push_back(3 * 32 + 5'h11);
        gq.push_back(1);  sq.push_back(0 * 32 + 5'h04);
        req[0] = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(0);
            if (k > 0) chk("rr_spacing", cyc - prev, 3);
            prev = cyc;
        end
        req[0] = 4'b0000;
        idle(4);

        // Single request; a request raised and dropped while busy is ignored.
        one(0, 0, 4'hA, 4'h3, 5'h0D);
        req[0] = 4'b1000;
        idle(1);
        req[0] = 4'b0000;
        idle(4);
        chk("hold_sum", 32'(sum_out[0]), 5'h0D);
        chk("hold_id", 32'(sum_id[0]), 0);

        // Carry kept in the fifth bit.
        one(0, 2, 4'hF, 4'hF, 5'h1E);
        idle(3);
        one(0, 2, 4'hE, 4'h1, 5'h0F);
        idle(3);
        chk("hold_id2", 32'(sum_id[0]), 2);

        // Reset in the middle of a calculation abandons it.
        one(0, 1, 4'h2, 4'h2, -1);
        idle(1);
        chk("busy_calc", 32'(busy[0]), 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("midreset");
        idle(2);
        rst_n = 1'b1;
        idle(1);
        a[0] = 16'h0075;
        b[0] = 16'h0076;
        gq.push_back(1);  sq.push_back(0 * 32 + 5'h0B);
        gq.push_back(2);  sq.push_back(1 * 32 + 5'h0E);
        req[0] = 4'b0011;
        wait_gnt(0);
        req[0] = 4'b0010;
        wait_gnt(0);
        req[0] = 4'b0000;
        idle(4);

        // ADD_LAT=1: operand change after grant must not leak in.
        one(1, 0, 4'h3, 4'h4, 5'h07);
        a[1][3:0] = 4'hF;
        b[1][3:0] = 4'hF;
        idle(3);
        a[1] = 16'h0052;
        b[1] = 16'h00C9;
        gq.push_back(256 + 2);  sq.push_back(256 + 1 * 32 + 5'h11);
        gq.push_back(256 + 1);  sq.push_back(256 + 0 * 32 + 5'h0B);
        req[1] = 4'b0011;
        wait_gnt(1);
        prev = cyc;
        wait_gnt(1);
        chk("b2b_spacing", cyc - prev, 2);
        req[1] = 4'b0000;
        idle(4);

        chk("gq_drained", gq.size(), 0);
        chk("sq_drained", sq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
